// File: rtl/apb_fifo_slave_pkg.sv
// Shared constants for the APB FIFO completer: FSM encodings, register
// selects, and STATUS/CTRL bit positions.
package apb_fifo_slave_pkg;

  // FSM encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Register select, taken from PADDR[3:2]
  localparam logic [1:0] SEL_DATA   = 2'd0;
  localparam logic [1:0] SEL_STATUS = 2'd1;
  localparam logic [1:0] SEL_CTRL   = 2'd2;
  localparam logic [1:0] SEL_BAD    = 2'd3;

  // STATUS bit positions
  localparam int STAT_TX_EMPTY = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_RX_EMPTY = 2;
  localparam int STAT_RX_FULL  = 3;
  localparam int STAT_RX_OVF   = 4;

  // CTRL bit positions
  localparam int CTRL_TX_FLUSH  = 0;
  localparam int CTRL_RX_FLUSH  = 1;
  localparam int CTRL_OVF_CLEAR = 2;
  localparam int CTRL_WAIT_LSB  = 4;
  localparam int WAIT_W         = 4;

  // Request captured at the setup phase
  typedef struct packed {
    logic       write;
    logic [1:0] sel;
    logic       err;
  } req_t;

endpackage

// File: rtl/apb_fifo_slave_if.sv
// APB completer-side bus bundle.
interface apb_fifo_slave_if #(
  parameter int addr_width = 32,
  parameter int data_width = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [addr_width-1:0] PADDR;
  logic [data_width-1:0] PWDATA;
  logic [data_width-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_fifo_slave_sync_fifo.sv
// Single-clock FIFO with flush; push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage write; a flushed push leaves a stale word that is never read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy tracking; flush overrides same-cycle push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/apb_fifo_slave.sv
// APB completer exposing a TX FIFO, an RX FIFO, STATUS and CTRL registers,
// with programmable wait states.
//
// state | meaning
// IDLE  | waiting for a setup phase
// WAIT  | inserting wait states, PREADY low
// RESP  | PREADY high, side effect applied at the closing edge
module apb_fifo_slave
  import apb_fifo_slave_pkg::*;
#(
  parameter int addr_width = 32,
  parameter int data_width = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  apb_fifo_slave_if.slave       apb,
  output logic [data_width-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_pop,
  input  logic [data_width-1:0] rx_data,
  input  logic                  rx_push
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]            state;
  logic [WAIT_W-1:0]     cnt;
  logic [WAIT_W-1:0]     wait_cfg;
  logic                  rx_ovf;
  req_t                  lat;
  logic [data_width-1:0] lat_wdata;

  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0]         tx_count, rx_count;
  logic [data_width-1:0] rx_head;

  logic [1:0]            dec_sel;
  logic                  dec_err;
  logic [1:0]            cur_sel;
  logic                  cur_err, cur_write;
  logic [data_width-1:0] status_word, rd_word;
  logic                  fire, tx_push, rx_pop, ctrl_wr;
  logic                  tx_flush, rx_flush, ovf_clear;

  // Address decode and error evaluation for the current setup phase
  always_comb begin
    dec_sel = apb.PADDR[3:2];
    dec_err = (apb.PADDR[1:0] != 2'b00)
           || (apb.PADDR[addr_width-1:4] != '0)
           || (dec_sel == SEL_BAD)
           || (dec_sel == SEL_STATUS && apb.PWRITE)
           || (dec_sel == SEL_DATA && apb.PWRITE && tx_full)
           || (dec_sel == SEL_DATA && !apb.PWRITE && rx_empty);
  end

  // In IDLE the response comes straight from the live decode; otherwise from the latch
  assign cur_sel   = (state == ST_IDLE) ? dec_sel      : lat.sel;
  assign cur_err   = (state == ST_IDLE) ? dec_err      : lat.err;
  assign cur_write = (state == ST_IDLE) ? apb.PWRITE   : lat.write;

  // STATUS snapshot
  always_comb begin
    status_word                = '0;
    status_word[STAT_TX_EMPTY] = tx_empty;
    status_word[STAT_TX_FULL]  = tx_full;
    status_word[STAT_RX_EMPTY] = rx_empty;
    status_word[STAT_RX_FULL]  = rx_full;
    status_word[STAT_RX_OVF]   = rx_ovf;
    status_word[15:8]          = 8'(tx_count);
    status_word[23:16]         = 8'(rx_count);
  end

  // Read data loaded into PRDATA on RESP entry; errors and writes return 0
  always_comb begin
    rd_word = '0;
    if (!cur_err && !cur_write) begin
      case (cur_sel)
        SEL_DATA:   rd_word = rx_head;
        SEL_STATUS: rd_word = status_word;
        SEL_CTRL:   rd_word[CTRL_WAIT_LSB +: WAIT_W] = wait_cfg;
        default:    rd_word = '0;
      endcase
    end
  end

  // APB transfer FSM with registered outputs
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      lat         <= '0;
      lat_wdata   <= '0;
      apb.PREADY  <= 1'b0;
      apb.PSLVERR <= 1'b0;
      apb.PRDATA  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          apb.PREADY  <= 1'b0;
          apb.PSLVERR <= 1'b0;
          apb.PRDATA  <= '0;
          if (apb.PSEL && !apb.PENABLE) begin
            lat.write <= apb.PWRITE;
            lat.sel   <= dec_sel;
            lat.err   <= dec_err;
            lat_wdata <= apb.PWDATA;
            if (wait_cfg == '0) begin
              state       <= ST_RESP;
              apb.PREADY  <= 1'b1;
              apb.PSLVERR <= dec_err;
              apb.PRDATA  <= rd_word;
            end else begin
              state <= ST_WAIT;
              cnt   <= wait_cfg - WAIT_W'(1);
            end
          end
        end
        ST_WAIT: begin
          if (!apb.PSEL) begin
            state <= ST_IDLE;
          end else if (cnt == '0) begin
            state       <= ST_RESP;
            apb.PREADY  <= 1'b1;
            apb.PSLVERR <= lat.err;
            apb.PRDATA  <= rd_word;
          end else begin
            cnt <= cnt - WAIT_W'(1);
          end
        end
        ST_RESP: begin
          state       <= ST_IDLE;
          apb.PREADY  <= 1'b0;
          apb.PSLVERR <= 1'b0;
          apb.PRDATA  <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Side effects fire at the RESP closing edge, only if the master is still selecting us
  assign fire      = (state == ST_RESP) && apb.PSEL && !lat.err;
  assign tx_push   = fire && lat.write && (lat.sel == SEL_DATA);
  assign rx_pop    = fire && !lat.write && (lat.sel == SEL_DATA);
  assign ctrl_wr   = fire && lat.write && (lat.sel == SEL_CTRL);
  assign tx_flush  = ctrl_wr && lat_wdata[CTRL_TX_FLUSH];
  assign rx_flush  = ctrl_wr && lat_wdata[CTRL_RX_FLUSH];
  assign ovf_clear = ctrl_wr && lat_wdata[CTRL_OVF_CLEAR];

  // CTRL wait setting and sticky RX overflow; a new overflow beats a same-cycle clear
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      wait_cfg <= '0;
      rx_ovf   <= 1'b0;
    end else begin
      if (ctrl_wr) wait_cfg <= lat_wdata[CTRL_WAIT_LSB +: WAIT_W];
      if (rx_push && rx_full) rx_ovf <= 1'b1;
      else if (ovf_clear)     rx_ovf <= 1'b0;
    end
  end

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(data_width)) u_tx_fifo (
    .clk   (PCLK),
    .rst_n (PRESET),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (tx_flush),
    .wdata (lat_wdata),
    .rdata (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(data_width)) u_rx_fifo (
    .clk   (PCLK),
    .rst_n (PRESET),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (rx_flush),
    .wdata (rx_data),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  assign tx_valid = !tx_empty;
endmodule

// File: tb/tb_apb_fifo_slave.sv
// Bench for apb_fifo_slave: directed vector table, hand sequences for
// multi-cycle corners, and a randomized run against a queue-based model.
module tb_apb_fifo_slave;
  localparam int DEPTH = 8;

  logic        PCLK;
  logic        PRESET;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_pop;
  logic [31:0] rx_data;
  logic        rx_push;

  int checks = 0;
  int errors = 0;

  apb_fifo_slave_if #(.addr_width(32), .data_width(32)) bus ();

  apb_fifo_slave #(.addr_width(32), .data_width(32), .FIFO_DEPTH(DEPTH)) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .apb      (bus),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_pop   (tx_pop),
    .rx_data  (rx_data),
    .rx_push  (rx_push)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Reference model state
  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  logic [3:0]  m_wait;
  logic        m_ovf;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_waits;
  } vec_t;

  vec_t        vecs[12];
  logic [31:0] addr_pool[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s        = '0;
    s[0]     = (tx_q.size() == 0);
    s[1]     = (tx_q.size() == DEPTH);
    s[2]     = (rx_q.size() == 0);
    s[3]     = (rx_q.size() == DEPTH);
    s[4]     = m_ovf;
    s[15:8]  = 8'(tx_q.size());
    s[23:16] = 8'(rx_q.size());
    return s;
  endfunction

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic push_end, input logic [31:0] push_data,
                          output logic [31:0] rdata, output logic err, output int waits);
    @(negedge PCLK);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
    bus.PADDR = addr; bus.PWDATA = wdata;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    waits = 0;
    while (!bus.PREADY && waits < 40) begin
      @(negedge PCLK);
      waits++;
    end
    if (!bus.PREADY) begin
      checks++;
      errors++;
      $display("FAIL pready_timeout actual=0 expected=1 addr=%h", addr);
    end
    rdata = bus.PRDATA;
    err   = bus.PSLVERR;
    if (push_end) begin
      rx_push = 1'b1;
      rx_data = push_data;
    end
    @(negedge PCLK);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    rx_push = 1'b0;
  endtask

  task automatic xfer_chk(input string nm, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic exp_err,
                          input logic [31:0] exp_rd, input int exp_waits);
    logic [31:0] rd;
    logic        er;
    int          w;
    apb_xfer(wr, addr, wdata, 1'b0, 32'h0, rd, er, w);
    chk({nm, " pslverr"}, 32'(er), 32'(exp_err));
    chk({nm, " prdata"}, rd, exp_rd);
    chk({nm, " waits"}, 32'(w), 32'(exp_waits));
  endtask

  task automatic pulse(input logic pop, input logic push, input logic [31:0] d);
    @(negedge PCLK);
    tx_pop = pop; rx_push = push; rx_data = d;
    @(negedge PCLK);
    tx_pop = 1'b0; rx_push = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          w;
    logic        wr;
    logic [31:0] addr, wdata, exp_rd;
    logic        exp_err;
    logic [1:0]  sel;

    vecs[0]  = '{1'b1, 32'h0,  32'hA5A5_0001, 1'b0, 32'h0,         0};
    vecs[1]  = '{1'b0, 32'h4,  32'h0,         1'b0, 32'h0000_0104, 0};
    vecs[2]  = '{1'b1, 32'h8,  32'h30,        1'b0, 32'h0,         0};
    vecs[3]  = '{1'b0, 32'h8,  32'h0,         1'b0, 32'h30,        3};
    vecs[4]  = '{1'b0, 32'hC,  32'h0,         1'b1, 32'h0,         3};
    vecs[5]  = '{1'b0, 32'h0,  32'h0,         1'b1, 32'h0,         3};
    vecs[6]  = '{1'b1, 32'h4,  32'h1,         1'b1, 32'h0,         3};
    vecs[7]  = '{1'b0, 32'h2,  32'h0,         1'b1, 32'h0,         3};
    vecs[8]  = '{1'b1, 32'h8,  32'h01,        1'b0, 32'h0,         3};
    vecs[9]  = '{1'b0, 32'h4,  32'h0,         1'b0, 32'h0000_0005, 0};
    vecs[10] = '{1'b0, 32'h10, 32'h0,         1'b1, 32'h0,         0};
    vecs[11] = '{1'b0, 32'h8,  32'h0,         1'b0, 32'h0,         0};

    addr_pool = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h8, 32'hC, 32'h2, 32'h10, 32'h8000_0000};

    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = '0; bus.PWDATA = '0;
    tx_pop = 1'b0; rx_push = 1'b0; rx_data = '0;
    PRESET = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("reset pready", 32'(bus.PREADY), 32'h0);
    chk("reset pslverr", 32'(bus.PSLVERR), 32'h0);
    chk("reset prdata", bus.PRDATA, 32'h0);
    chk("reset tx_valid", 32'(tx_valid), 32'h0);
    PRESET = 1'b1;

    // First write, zero waits, lands at the TX head
    xfer_chk("first_write", 1'b1, 32'h0, 32'hA5A5_0001, 1'b0, 32'h0, 0);
    chk("first_write tx_valid", 32'(tx_valid), 32'h1);
    chk("first_write tx_data", tx_data, 32'hA5A5_0001);
    xfer_chk("flush_tx", 1'b1, 32'h8, 32'h1, 1'b0, 32'h0, 0);
    chk("flush_tx tx_valid", 32'(tx_valid), 32'h0);

    // Directed vector table
    for (int i = 0; i < 12; i++)
      xfer_chk($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
               vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].exp_waits);

    // TX fill to full, overflow write rejected, contents intact
    for (int i = 0; i < DEPTH; i++)
      xfer_chk("tx_fill", 1'b1, 32'h0, 32'h100 + 32'(i), 1'b0, 32'h0, 0);
    xfer_chk("tx_overfill", 1'b1, 32'h0, 32'hDEAD, 1'b1, 32'h0, 0);
    xfer_chk("tx_full_status", 1'b0, 32'h4, 32'h0, 1'b0, 32'h0000_0806, 0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("tx_drain valid", 32'(tx_valid), 32'h1);
      chk("tx_drain data", tx_data, 32'h100 + 32'(i));
      pulse(1'b1, 1'b0, 32'h0);
    end
    chk("tx_drained valid", 32'(tx_valid), 32'h0);

    // RX ordering
    pulse(1'b0, 1'b1, 32'h11);
    pulse(1'b0, 1'b1, 32'h22);
    xfer_chk("rx_read0", 1'b0, 32'h0, 32'h0, 1'b0, 32'h11, 0);
    xfer_chk("rx_read1", 1'b0, 32'h0, 32'h0, 1'b0, 32'h22, 0);
    xfer_chk("rx_empty_status", 1'b0, 32'h4, 32'h0, 1'b0, 32'h0000_0005, 0);

    // RX overflow, clear, and same-edge push/pop
    for (int i = 0; i < DEPTH + 1; i++) pulse(1'b0, 1'b1, 32'h40 + 32'(i));
    xfer_chk("rx_ovf_status", 1'b0, 32'h4, 32'h0, 1'b0, 32'h0008_0019, 0);
    xfer_chk("ovf_clear", 1'b1, 32'h8, 32'h4, 1'b0, 32'h0, 0);
    xfer_chk("ovf_cleared_status", 1'b0, 32'h4, 32'h0, 1'b0, 32'h0008_0009, 0);
    xfer_chk("rx_pop_one", 1'b0, 32'h0, 32'h0, 1'b0, 32'h40, 0);
    apb_xfer(1'b0, 32'h0, 32'h0, 1'b1, 32'h99, rd, er, w);
    chk("pop_push rdata", rd, 32'h41);
    chk("pop_push pslverr", 32'(er), 32'h0);
    xfer_chk("pop_push_status", 1'b0, 32'h4, 32'h0, 1'b0, 32'h0007_0001, 0);

    // Reset while in WAIT
    xfer_chk("set_wait3", 1'b1, 32'h8, 32'h30, 1'b0, 32'h0, 0);
    for (int i = 0; i < 3; i++)
      xfer_chk("tx_push3", 1'b1, 32'h0, 32'h200 + 32'(i), 1'b0, 32'h0, 3);
    @(negedge PCLK);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 32'h4;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    #1;
    chk("midreset pready", 32'(bus.PREADY), 32'h0);
    chk("midreset tx_valid", 32'(tx_valid), 32'h0);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b1;
    xfer_chk("after_reset_ctrl", 1'b0, 32'h8, 32'h0, 1'b0, 32'h0, 0);
    xfer_chk("after_reset_badaddr", 1'b0, 32'hC, 32'h0, 1'b1, 32'h0, 0);
    xfer_chk("after_reset_status", 1'b0, 32'h4, 32'h0, 1'b0, 32'h0000_0005, 0);

    // Randomized run against the queue model, starting from reset state
    tx_q.delete(); rx_q.delete(); m_wait = '0; m_ovf = 1'b0;
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        logic p, q;
        logic [31:0] d;
        p = ($urandom_range(0, 2) == 0);
        q = ($urandom_range(0, 1) == 0);
        d = $urandom;
        pulse(p, q, d);
        if (p && tx_q.size() > 0) void'(tx_q.pop_front());
        if (q) begin
          if (rx_q.size() == DEPTH) m_ovf = 1'b1;
          else rx_q.push_back(d);
        end
        chk("rnd tx_valid", 32'(tx_valid), 32'(tx_q.size() != 0));
        if (tx_q.size() != 0) chk("rnd tx_data", tx_data, tx_q[0]);
      end else begin
        wr   = 1'($urandom_range(0, 1));
        addr = addr_pool[$urandom_range(0, 9)];
        if (addr == 32'h8 && wr)
          wdata = (32'($urandom_range(0, 3)) << 4) |
                  (($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 7)) : 32'h0);
        else
          wdata = $urandom;
        sel = addr[3:2];
        exp_err = (addr[1:0] != 2'b00) || (addr[31:4] != 28'h0) || (sel == 2'd3)
               || (sel == 2'd1 && wr)
               || (sel == 2'd0 && wr && tx_q.size() == DEPTH)
               || (sel == 2'd0 && !wr && rx_q.size() == 0);
        exp_rd = 32'h0;
        if (!exp_err && !wr) begin
          if (sel == 2'd0)      exp_rd = rx_q[0];
          else if (sel == 2'd1) exp_rd = m_status();
          else                  exp_rd = 32'(m_wait) << 4;
        end
        xfer_chk("rnd", wr, addr, wdata, exp_err, exp_rd, int'(m_wait));
        if (!exp_err) begin
          if (sel == 2'd0 && wr)  tx_q.push_back(wdata);
          if (sel == 2'd0 && !wr) void'(rx_q.pop_front());
          if (sel == 2'd2 && wr) begin
            if (wdata[0]) tx_q.delete();
            if (wdata[1]) rx_q.delete();
            if (wdata[2]) m_ovf = 1'b0;
            m_wait = wdata[7:4];
          end
        end
      end
    end
    exp_rd = m_status();
    xfer_chk("rnd_final_status", 1'b0, 32'h4, 32'h0, 1'b0, exp_rd, int'(m_wait));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
